// File: rtl/tag_stream_feeder.sv
// Stripe-stage feeder: broadcasts job config, walks two strided tag/address
// sequences, and streams SRAM operand pairs through a 1-entry skid buffer.
// Optional stall perf counter is built when STREAM_PERF_CNT_EN is defined.
module tag_stream_feeder #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned BlockWidth = 128,
    parameter int unsigned TagWidth   = 12,
    parameter int unsigned InstrWidth = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [InstrWidth-1:0] cfg_instr,
    input  logic [TagWidth-1:0]   cfg_tag_a,
    input  logic [TagWidth-1:0]   cfg_tag_b,
    input  logic [TagWidth-1:0]   cfg_stride_a,
    input  logic [TagWidth-1:0]   cfg_stride_b,
    input  logic [TagWidth-1:0]   cfg_iter_lim,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [TagWidth-1:0]   mem_rd_addr_a,
    output logic [TagWidth-1:0]   mem_rd_addr_b,
    input  logic [BlockWidth-1:0] mem_rd_data_a,
    input  logic [BlockWidth-1:0] mem_rd_data_b,
    output logic                  en_tag_write,
    output logic [TagWidth-1:0]   tagA_OUT,
    output logic [TagWidth-1:0]   tagB_OUT,
    output logic [TagWidth-1:0]   strideA_OUT,
    output logic [TagWidth-1:0]   strideB_OUT,
    output logic [TagWidth-1:0]   iter_lim_OUT,
    output logic [InstrWidth-1:0] instr_OUT,
    output logic [BlockWidth-1:0] d0_OUT,
    output logic [BlockWidth-1:0] d1_OUT,
    output logic                  valid_OUT,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cycles
);

    // Each operand block must split evenly into PE words.
    if (BlockWidth % DataWidth != 0) begin : g_bad_width
        $error("BlockWidth must be a multiple of DataWidth");
    end

    typedef enum logic [2:0] {StIdle, StCfg, StStream, StDrain, StFin} state_e;

    state_e r_state, w_state_next;

    logic [TagWidth-1:0]   r_cfg_tag_a, r_cfg_tag_b;
    logic [TagWidth-1:0]   r_stride_a, r_stride_b, r_iter_lim;
    logic [InstrWidth-1:0] r_instr;
    logic [TagWidth-1:0]   r_addr_a, r_addr_b, r_k;
    logic                  r_inflight;
    logic [TagWidth-1:0]   r_inf_tag_a, r_inf_tag_b;
    logic                  r_skid_vld;
    logic [TagWidth-1:0]   r_skid_tag_a, r_skid_tag_b;
    logic [BlockWidth-1:0] r_skid_d0, r_skid_d1;
    logic                  r_out_vld;
    logic [TagWidth-1:0]   r_out_tag_a, r_out_tag_b;
    logic [BlockWidth-1:0] r_out_d0, r_out_d1;

    logic w_start_job, w_issue, w_last_issue, w_drained, w_busy;

    assign w_start_job  = (r_state == StIdle) && start;
    // Hold issue while the skid buffer is occupied so it always drains first.
    assign w_issue      = (r_state == StStream) && !stall && !r_skid_vld;
    assign w_last_issue = w_issue && (r_k == r_iter_lim - TagWidth'(1));
    assign w_drained    = !r_inflight && !r_skid_vld && (!r_out_vld || !stall);
    assign w_busy       = (r_state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (start) w_state_next = StCfg;
            StCfg:    w_state_next = (r_iter_lim == '0) ? StFin : StStream;
            StStream: if (w_last_issue) w_state_next = StDrain;
            StDrain:  if (w_drained) w_state_next = StFin;
            StFin:    w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        en_tag_write = (r_state == StCfg);
        busy         = w_busy;
        done         = (r_state == StFin);
        mem_rd_en    = w_issue;
        tagA_OUT     = (r_state == StCfg) ? r_cfg_tag_a : r_out_tag_a;
        tagB_OUT     = (r_state == StCfg) ? r_cfg_tag_b : r_out_tag_b;
    end

    assign mem_rd_addr_a = r_addr_a;
    assign mem_rd_addr_b = r_addr_b;
    assign strideA_OUT   = r_stride_a;
    assign strideB_OUT   = r_stride_b;
    assign iter_lim_OUT  = r_iter_lim;
    assign instr_OUT     = r_instr;
    assign d0_OUT        = r_out_d0;
    assign d1_OUT        = r_out_d1;
    assign valid_OUT     = r_out_vld;

    // Job config and running address adders.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_tag_a <= '0;
            r_cfg_tag_b <= '0;
            r_stride_a  <= '0;
            r_stride_b  <= '0;
            r_iter_lim  <= '0;
            r_instr     <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_k         <= '0;
        end else if (w_start_job) begin
            r_cfg_tag_a <= cfg_tag_a;
            r_cfg_tag_b <= cfg_tag_b;
            r_stride_a  <= cfg_stride_a;
            r_stride_b  <= cfg_stride_b;
            r_iter_lim  <= cfg_iter_lim;
            r_instr     <= cfg_instr;
            r_addr_a    <= cfg_tag_a;
            r_addr_b    <= cfg_tag_b;
            r_k         <= '0;
        end else if (w_issue) begin
            r_addr_a <= r_addr_a + r_stride_a;
            r_addr_b <= r_addr_b + r_stride_b;
            r_k      <= r_k + TagWidth'(1);
        end
    end

    // Return path: in-flight read -> output register, or skid buffer under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight   <= 1'b0;
            r_inf_tag_a  <= '0;
            r_inf_tag_b  <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_tag_a <= '0;
            r_skid_tag_b <= '0;
            r_skid_d0    <= '0;
            r_skid_d1    <= '0;
            r_out_vld    <= 1'b0;
            r_out_tag_a  <= '0;
            r_out_tag_b  <= '0;
            r_out_d0     <= '0;
            r_out_d1     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_tag_a <= r_addr_a;
                r_inf_tag_b <= r_addr_b;
            end
            if (stall) begin
                if (r_inflight) begin
                    r_skid_vld   <= 1'b1;
                    r_skid_tag_a <= r_inf_tag_a;
                    r_skid_tag_b <= r_inf_tag_b;
                    r_skid_d0    <= mem_rd_data_a;
                    r_skid_d1    <= mem_rd_data_b;
                end
            end else if (r_skid_vld) begin
                r_skid_vld  <= 1'b0;
                r_out_vld   <= 1'b1;
                r_out_tag_a <= r_skid_tag_a;
                r_out_tag_b <= r_skid_tag_b;
                r_out_d0    <= r_skid_d0;
                r_out_d1    <= r_skid_d1;
            end else if (r_inflight) begin
                r_out_vld   <= 1'b1;
                r_out_tag_a <= r_inf_tag_a;
                r_out_tag_b <= r_inf_tag_b;
                r_out_d0    <= mem_rd_data_a;
                r_out_d1    <= mem_rd_data_b;
            end else begin
                r_out_vld <= 1'b0;
            end
        end
    end

`ifdef STREAM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_job) begin
            r_stall_cnt <= '0;
        end else if (w_busy && stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_tag_stream_feeder.sv
// Directed bench for tag_stream_feeder: SRAM model with 1-cycle read latency,
// hand-computed address/tag/data expectations per cycle.
module tb_tag_stream_feeder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [6:0]   cfg_instr = '0;
    logic [11:0]  cfg_tag_a = '0, cfg_tag_b = '0;
    logic [11:0]  cfg_stride_a = '0, cfg_stride_b = '0, cfg_iter_lim = '0;
    logic         stall = 1'b0;
    logic         mem_rd_en;
    logic [11:0]  mem_rd_addr_a, mem_rd_addr_b;
    logic [127:0] mem_rd_data_a = '0, mem_rd_data_b = '0;
    logic         en_tag_write;
    logic [11:0]  tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT, iter_lim_OUT;
    logic [6:0]   instr_OUT;
    logic [127:0] d0_OUT, d1_OUT;
    logic         valid_OUT, busy, done;
    logic [31:0]  stall_cycles;

    int n_vec  = 0;
    int n_fail = 0;

`ifdef STREAM_PERF_CNT_EN
    localparam logic [31:0] PerfMid = 32'd3;
    localparam logic [31:0] PerfEnd = 32'd5;
`else
    localparam logic [31:0] PerfMid = 32'd0;
    localparam logic [31:0] PerfEnd = 32'd0;
`endif

    tag_stream_feeder dut (
        .clk(clk), .rst(rst), .start(start), .cfg_instr(cfg_instr),
        .cfg_tag_a(cfg_tag_a), .cfg_tag_b(cfg_tag_b),
        .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b),
        .cfg_iter_lim(cfg_iter_lim), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_rd_addr_a(mem_rd_addr_a), .mem_rd_addr_b(mem_rd_addr_b),
        .mem_rd_data_a(mem_rd_data_a), .mem_rd_data_b(mem_rd_data_b),
        .en_tag_write(en_tag_write), .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
        .strideA_OUT(strideA_OUT), .strideB_OUT(strideB_OUT), .iter_lim_OUT(iter_lim_OUT),
        .instr_OUT(instr_OUT), .d0_OUT(d0_OUT), .d1_OUT(d1_OUT), .valid_OUT(valid_OUT),
        .busy(busy), .done(done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat_a(input logic [11:0] a);
        return {8'hA5, 108'd0, a};
    endfunction

    function automatic logic [127:0] pat_b(input logic [11:0] a);
        return {8'h5B, 108'd0, a};
    endfunction

    // SRAM: data for the address presented with mem_rd_en appears next cycle.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data_a <= pat_a(mem_rd_addr_a);
            mem_rd_data_b <= pat_b(mem_rd_addr_b);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; start is a pulse, stall is applied for the new cycle.
    task automatic step(input logic s);
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = s;
        #1;
    endtask

    task automatic job(input logic [11:0] ta, input logic [11:0] sa, input logic [11:0] tb,
                       input logic [11:0] sb, input logic [11:0] il, input logic [6:0] ins);
        cfg_tag_a = ta; cfg_stride_a = sa;
        cfg_tag_b = tb; cfg_stride_b = sb;
        cfg_iter_lim = il; cfg_instr = ins;
        start = 1'b1;
        step(1'b0);
    endtask

    task automatic pair(input string tag, input logic [11:0] ta, input logic [11:0] tb);
        check({tag, "_valid"}, valid_OUT, 1'b1);
        check({tag, "_tagA"}, tagA_OUT, ta);
        check({tag, "_tagB"}, tagB_OUT, tb);
        check({tag, "_d0"}, d0_OUT, pat_a(ta));
        check({tag, "_d1"}, d1_OUT, pat_b(tb));
    endtask

    task automatic issue(input string tag, input logic [11:0] aa, input logic [11:0] ab);
        check({tag, "_rd_en"}, mem_rd_en, 1'b1);
        check({tag, "_addr_a"}, mem_rd_addr_a, aa);
        check({tag, "_addr_b"}, mem_rd_addr_b, ab);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid_OUT, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_tagA", tagA_OUT, 12'h000);
        check("rst_perf", stall_cycles, 32'd0);
        #4 rst = 1'b1;

        // Job 1: basic strided stream, no stall
        job(12'h010, 12'h002, 12'h100, 12'h001, 12'd4, 7'h2A);
        check("j1_cfg_en", en_tag_write, 1'b1);
        check("j1_cfg_tagA", tagA_OUT, 12'h010);
        check("j1_cfg_tagB", tagB_OUT, 12'h100);
        check("j1_cfg_strA", strideA_OUT, 12'h002);
        check("j1_cfg_strB", strideB_OUT, 12'h001);
        check("j1_cfg_lim", iter_lim_OUT, 12'd4);
        check("j1_cfg_instr", instr_OUT, 7'h2A);
        check("j1_cfg_busy", busy, 1'b1);
        check("j1_cfg_rd_en", mem_rd_en, 1'b0);
        step(1'b0);
        issue("j1_k0", 12'h010, 12'h100);
        check("j1_k0_en_tag", en_tag_write, 1'b0);
        step(1'b0);
        issue("j1_k1", 12'h012, 12'h101);
        check("j1_k1_valid", valid_OUT, 1'b0);
        step(1'b0);
        issue("j1_k2", 12'h014, 12'h102);
        pair("j1_p0", 12'h010, 12'h100);
        step(1'b0);
        issue("j1_k3", 12'h016, 12'h103);
        pair("j1_p1", 12'h012, 12'h101);
        step(1'b0);
        check("j1_dr_rd_en", mem_rd_en, 1'b0);
        pair("j1_p2", 12'h014, 12'h102);
        step(1'b0);
        pair("j1_p3", 12'h016, 12'h103);
        check("j1_p3_done", done, 1'b0);
        step(1'b0);
        check("j1_fin_done", done, 1'b1);
        check("j1_fin_valid", valid_OUT, 1'b0);
        step(1'b0);
        check("j1_idle_done", done, 1'b0);
        check("j1_idle_busy", busy, 1'b0);
        check("j1_idle_strA", strideA_OUT, 12'h002);

        // Job 2: iter_lim = 0
        job(12'h055, 12'h001, 12'h066, 12'h001, 12'd0, 7'h11);
        check("j2_cfg_en", en_tag_write, 1'b1);
        check("j2_cfg_rd_en", mem_rd_en, 1'b0);
        step(1'b0);
        check("j2_fin_done", done, 1'b1);
        check("j2_fin_en", en_tag_write, 1'b0);
        check("j2_fin_rd_en", mem_rd_en, 1'b0);
        step(1'b0);
        check("j2_idle_done", done, 1'b0);
        check("j2_idle_rd_en", mem_rd_en, 1'b0);

        // Job 3: address wrap mod 2^12
        job(12'hFFE, 12'h001, 12'hFFD, 12'h003, 12'd4, 7'h03);
        step(1'b0);
        issue("j3_k0", 12'hFFE, 12'hFFD);
        step(1'b0);
        issue("j3_k1", 12'hFFF, 12'h000);
        step(1'b0);
        issue("j3_k2", 12'h000, 12'h003);
        pair("j3_p0", 12'hFFE, 12'hFFD);
        step(1'b0);
        issue("j3_k3", 12'h001, 12'h006);
        pair("j3_p1", 12'hFFF, 12'h000);
        step(1'b0);
        pair("j3_p2", 12'h000, 12'h003);
        step(1'b0);
        pair("j3_p3", 12'h001, 12'h006);
        step(1'b0);
        check("j3_done", done, 1'b1);
        step(1'b0);

        // Job 4: stall with skid buffer, then stall during drain (5 stall cycles)
        job(12'h020, 12'h004, 12'h200, 12'h008, 12'd3, 7'h44);
        step(1'b0);
        issue("j4_k0", 12'h020, 12'h200);
        step(1'b0);
        issue("j4_k1", 12'h024, 12'h208);
        step(1'b1);
        check("j4_s1_rd_en", mem_rd_en, 1'b0);
        pair("j4_s1", 12'h020, 12'h200);
        step(1'b1);
        check("j4_s2_rd_en", mem_rd_en, 1'b0);
        pair("j4_s2", 12'h020, 12'h200);
        step(1'b1);
        check("j4_s3_rd_en", mem_rd_en, 1'b0);
        pair("j4_s3", 12'h020, 12'h200);
        step(1'b0);
        check("j4_perf_mid", stall_cycles, PerfMid);
        check("j4_skid_first_rd_en", mem_rd_en, 1'b0);
        pair("j4_p0_go", 12'h020, 12'h200);
        step(1'b0);
        pair("j4_p1", 12'h024, 12'h208);
        issue("j4_k2", 12'h028, 12'h210);
        step(1'b0);
        check("j4_gap_valid", valid_OUT, 1'b0);
        check("j4_gap_rd_en", mem_rd_en, 1'b0);
        step(1'b1);
        pair("j4_p2_hold", 12'h028, 12'h210);
        step(1'b1);
        check("j4_hold_done", done, 1'b0);
        step(1'b0);
        pair("j4_p2_go", 12'h028, 12'h210);
        check("j4_go_done", done, 1'b0);
        step(1'b0);
        check("j4_done", done, 1'b1);
        check("j4_perf_end", stall_cycles, PerfEnd);
        step(1'b0);
        check("j4_perf_idle", stall_cycles, PerfEnd);

        // Job 5: asynchronous reset mid-stream, then a clean job
        job(12'h040, 12'h001, 12'h080, 12'h001, 12'd6, 7'h05);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        issue("j5_k2", 12'h042, 12'h082);
        check("j5_k2_valid", valid_OUT, 1'b1);
        rst = 1'b0;
        #1;
        check("j5_rst_busy", busy, 1'b0);
        check("j5_rst_valid", valid_OUT, 1'b0);
        check("j5_rst_rd_en", mem_rd_en, 1'b0);
        check("j5_rst_addr", mem_rd_addr_a, 12'h000);
        check("j5_rst_strA", strideA_OUT, 12'h000);
        check("j5_rst_tagA", tagA_OUT, 12'h000);
        @(posedge clk);
        #1;
        check("j5_rst_done", done, 1'b0);
        check("j5_rst_busy2", busy, 1'b0);
        #3 rst = 1'b1;
        job(12'h300, 12'h010, 12'h301, 12'h010, 12'd2, 7'h06);
        check("j6_cfg_en", en_tag_write, 1'b1);
        check("j6_cfg_perf", stall_cycles, 32'd0);
        step(1'b0);
        issue("j6_k0", 12'h300, 12'h301);
        step(1'b0);
        issue("j6_k1", 12'h310, 12'h311);
        check("j6_k1_valid", valid_OUT, 1'b0);
        step(1'b0);
        pair("j6_p0", 12'h300, 12'h301);
        step(1'b0);
        pair("j6_p1", 12'h310, 12'h311);
        step(1'b0);
        check("j6_done", done, 1'b1);
        step(1'b0);
        check("j6_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
